hub_mgu_cell: RTL and testbench
===============================

Name: hub_mgu_cell

Overview:
- Self-contained minimal-gated-unit (MGU) recurrent cell.
- Folded binary MAC datapath computes the forget gate, then the candidate state, then the hidden-state update.
- Hidden state h is held internally across timesteps.
- Successor to the single-layer folded linear MGU wrapper: adds gate sequencing, activations, state update and a start/done handshake; widths, lane count and dimensions are generic.

Parameters:
- IDIM, 16, input feature count.
- ODIM, 8, hidden size.
- IWID, 8, signed Q1.(IWID-1) data/weight width.
- SDIM, 4, concatenated-vector lanes consumed per cycle; (IDIM+ODIM) % SDIM == 0 is required.
- CDIM, IDIM+ODIM, concatenated length (derived).
- FOLD, CDIM/SDIM, MAC cycles per gate (derived).
- AWID, 2*IWID+$clog2(CDIM)+1, accumulator width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin one timestep; accepted only in IDLE
- clear_h  in  1  zero h; honoured only in IDLE
- iFmap  in  IWID x IDIM  input vector x_t, sampled on the start-accepting edge
- iWeigF  in  IWID x ODIM*CDIM  forget weights, element [o*CDIM+c]
- iWeigH  in  IWID x ODIM*CDIM  candidate weights, same layout
- busy  out  1  high from the start-accepting edge until done
- done  out  1  one-cycle pulse, oHid valid
- oHid  out  IWID x ODIM  hidden state h

Behaviour:
- Single clock; reset synchronous, active-high.
- Reset state:
  - FSM=IDLE, busy=0, done=0, oHid/h=0, accumulators=0, fold counter=0.
  - rst mid-operation aborts the timestep; no done is issued.
- Concatenated vector v:
  - v[0..ODIM-1] = h (F phase) or f*h (H phase).
  - v[ODIM..CDIM-1] = latched x.
  - f*h per element = (f[o]*h[o])>>>(IWID-1).
- FSM:
  - IDLE: start=1 latches x, busy=1, clears accumulators, goes to FGATE. If clear_h=1 on the same edge, h is zeroed first and used as 0.
  - FGATE: FOLD cycles. Cycle p: acc[o] += sum over lanes s of W_F[o*CDIM+p*SDIM+s]*v[p*SDIM+s], all ODIM outputs in parallel. Then FACT.
  - FACT (1 cycle): z=acc>>>(IWID-1); f=sat(z>>>1 + 2^(IWID-2)) clamped to [0, 2^(IWID-1)-1]. Accumulators cleared. Then HCAND.
  - HCAND: FOLD cycles, same MAC with W_H and v built from f*h. Then HACT.
  - HACT (1 cycle): ht=sat(acc>>>(IWID-1)) clamped to [-2^(IWID-1), 2^(IWID-1)-1]. Then UPD.
  - UPD (1 cycle): h' = sat(h + ((f*(ht-h))>>>(IWID-1))). Difference is IWID+1 bits, product 2*IWID+1 bits. On this edge: oHid=h', done=1, busy=0, back to IDLE.
- Latency: done high exactly 2*FOLD+3 cycles after the start-accepting edge.
- Shifts are arithmetic, truncating toward -inf. No overflow is possible inside AWID.
- start while busy: ignored, no queuing. clear_h while busy: ignored.
- start and done on the same cycle: the FSM is already in IDLE, so start is accepted, giving back-to-back timesteps.
- oHid is stable between done pulses.

Optional Feature:
- Macro HUB_MGU_BIAS_EN.
- Defined:
  - Adds ports iBiasF, iBiasH (in, IWID x ODIM).
  - Accumulators initialise to bias<<(IWID-1) at the start of FGATE and HCAND respectively, instead of 0.
  - Latency unchanged.
- Undefined: no bias ports; accumulators initialise to 0.

Test Plan:
Use IDIM=4, ODIM=2, SDIM=2, IWID=8, so FOLD=3 and latency is 9.
- Reset: assert rst for 2 cycles -> oHid={0,0}, busy=0, done=0; start held high during rst has no effect.
- Zero weights, h preloaded to 100 via a prior step, x={5,5,5,5} -> f=64, ht=0, h'=100+((64*-100)>>>7)=50; done exactly 9 cycles after start.
- Positive saturation: clear_h+start, x={127,127,127,127}, all W_F=W_H=127 -> f=127, ht=127, oHid={126,126}.
- Negative saturation: same but all W_H=-128 -> ht=-128, oHid={-127,-127}.
- Busy protection: pulse start at cycles 1 and 4 -> one done only, at cycle 10. start on the done cycle -> second done 9 cycles later.
- Abort: rst at cycle 5 of a step -> no done, oHid={0,0}, busy=0; new start completes normally.

Source files
------------

// File: rtl/hub_mgu_cell_if.sv
// hub_mgu_cell_if: start/done handshake, operand and hidden-state bus of the MGU cell; bias ports exist only with HUB_MGU_BIAS_EN
interface hub_mgu_cell_if #(
  parameter int IDIM = 16,
  parameter int ODIM = 8,
  parameter int IWID = 8
);
  localparam int CDIM = IDIM + ODIM;
  logic start;
  logic clear_h;
  logic [IDIM-1:0][IWID-1:0] iFmap;
  logic [ODIM*CDIM-1:0][IWID-1:0] iWeigF;
  logic [ODIM*CDIM-1:0][IWID-1:0] iWeigH;
`ifdef HUB_MGU_BIAS_EN
  logic [ODIM-1:0][IWID-1:0] iBiasF;
  logic [ODIM-1:0][IWID-1:0] iBiasH;
`endif
  logic busy;
  logic done;
  logic [ODIM-1:0][IWID-1:0] oHid;
`ifdef HUB_MGU_BIAS_EN
  modport master (output start, clear_h, iFmap, iWeigF, iWeigH, iBiasF, iBiasH, input busy, done, oHid);
  modport slave (input start, clear_h, iFmap, iWeigF, iWeigH, iBiasF, iBiasH, output busy, done, oHid);
`else
  modport master (output start, clear_h, iFmap, iWeigF, iWeigH, input busy, done, oHid);
  modport slave (input start, clear_h, iFmap, iWeigF, iWeigH, output busy, done, oHid);
`endif
endinterface

// File: rtl/hub_mgu_cell.sv
// hub_mgu_cell: folded MGU recurrent cell (forget gate, candidate, state update); HUB_MGU_BIAS_EN adds gate biases
module hub_mgu_cell #(
  parameter int IDIM = 16,
  parameter int ODIM = 8,
  parameter int IWID = 8,
  parameter int SDIM = 4
) (
  input logic clk,
  input logic rst,
  hub_mgu_cell_if.slave bus
);
  localparam int CDIM = IDIM + ODIM;
  localparam int FOLD = CDIM / SDIM;
  localparam int AWID = 2 * IWID + $clog2(CDIM) + 1;
  localparam int CW = FOLD > 1 ? $clog2(FOLD) : 1;
  localparam logic signed [AWID-1:0] HI = AWID'(2 ** (IWID - 1) - 1);
  localparam logic signed [AWID-1:0] LO = AWID'(-(2 ** (IWID - 1)));
  localparam logic signed [AWID-1:0] HALF = AWID'(2 ** (IWID - 2));
  typedef enum logic [2:0] {IDLE, FGATE, FACT, HCAND, HACT, UPD} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic last;
  logic signed [IWID-1:0] x [IDIM];
  logic signed [IWID-1:0] h [ODIM];
  logic signed [IWID-1:0] f [ODIM];
  logic signed [IWID-1:0] ht [ODIM];
  logic signed [IWID-1:0] fh [ODIM];
  logic signed [IWID-1:0] fa [ODIM];
  logic signed [IWID-1:0] ha [ODIM];
  logic signed [IWID-1:0] hn [ODIM];
  logic signed [IWID-1:0] v [CDIM];
  logic signed [AWID-1:0] acc [ODIM];
  logic signed [AWID-1:0] mac [ODIM];
  logic signed [AWID-1:0] initf [ODIM];
  logic signed [AWID-1:0] inith [ODIM];
  logic signed [AWID-1:0] t;
  logic signed [IWID-1:0] w;
  function automatic logic signed [IWID-1:0] sat(input logic signed [AWID-1:0] a);
    return a > HI ? IWID'(HI) : a < LO ? IWID'(LO) : IWID'(a);
  endfunction
  assign last = cnt == CW'(FOLD - 1);
  // sequence the two gate passes, their activation cycles and the state update
  always_comb begin
    nxt = state == IDLE ? (bus.start ? FGATE : IDLE) :
          state == FGATE ? (last ? FACT : FGATE) :
          state == FACT ? HCAND :
          state == HCAND ? (last ? HACT : HCAND) :
          state == HACT ? UPD : IDLE;
  end
  // datapath: build v, fold one SDIM slice into every accumulator, and evaluate activations and update
  always_comb begin
    t = '0;
    w = '0;
    for (int o = 0; o < ODIM; o++) begin
      fh[o] = IWID'((AWID'(f[o]) * AWID'(h[o])) >>> (IWID - 1));
      v[o] = state == HCAND ? fh[o] : h[o];
`ifdef HUB_MGU_BIAS_EN
      initf[o] = AWID'(signed'(bus.iBiasF[o])) <<< (IWID - 1);
      inith[o] = AWID'(signed'(bus.iBiasH[o])) <<< (IWID - 1);
`else
      initf[o] = '0;
      inith[o] = '0;
`endif
    end
    for (int i = 0; i < IDIM; i++) v[ODIM+i] = x[i];
    for (int o = 0; o < ODIM; o++) begin
      mac[o] = acc[o];
      for (int s = 0; s < SDIM; s++) begin
        w = state == HCAND ? signed'(bus.iWeigH[o*CDIM+int'(cnt)*SDIM+s]) : signed'(bus.iWeigF[o*CDIM+int'(cnt)*SDIM+s]);
        mac[o] = mac[o] + AWID'(w) * AWID'(v[int'(cnt)*SDIM+s]);
      end
      t = ((acc[o] >>> (IWID - 1)) >>> 1) + HALF;
      fa[o] = t < 0 ? '0 : sat(t);
      ha[o] = sat(acc[o] >>> (IWID - 1));
      hn[o] = sat(AWID'(h[o]) + ((AWID'(f[o]) * (AWID'(ht[o]) - AWID'(h[o]))) >>> (IWID - 1)));
    end
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // registered datapath and handshake; clear_h takes effect before the forget pass reads h
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      x <= '{default: '0};
      h <= '{default: '0};
      f <= '{default: '0};
      ht <= '{default: '0};
      acc <= '{default: '0};
      bus.oHid <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.busy <= nxt != IDLE;
      bus.done <= state == UPD;
      cnt <= (state == FGATE || state == HCAND) && !last ? cnt + 1'b1 : '0;
      case (state)
        IDLE: if (bus.start) begin
          for (int i = 0; i < IDIM; i++) x[i] <= bus.iFmap[i];
          acc <= initf;
          if (bus.clear_h) h <= '{default: '0};
        end
        FGATE, HCAND: acc <= mac;
        FACT: begin
          f <= fa;
          acc <= inith;
        end
        HACT: ht <= ha;
        UPD: begin
          h <= hn;
          for (int o = 0; o < ODIM; o++) bus.oHid[o] <= hn[o];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hub_mgu_cell.sv
// tb_hub_mgu_cell: directed checks of reset, gating arithmetic, saturation, busy protection and abort
module tb_hub_mgu_cell;
  localparam int IDIM = 4;
  localparam int ODIM = 2;
  localparam int IWID = 8;
  localparam int SDIM = 2;
  localparam int CDIM = IDIM + ODIM;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int lat, n, d1, d2;
  hub_mgu_cell_if #(.IDIM(IDIM), .ODIM(ODIM), .IWID(IWID)) bus ();
  hub_mgu_cell #(.IDIM(IDIM), .ODIM(ODIM), .IWID(IWID), .SDIM(SDIM)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic set_in(input int xv, input int wf, input int wh);
    for (int i = 0; i < IDIM; i++) bus.iFmap[i] = IWID'(xv);
    for (int i = 0; i < ODIM * CDIM; i++) begin
      bus.iWeigF[i] = IWID'(wf);
      bus.iWeigH[i] = IWID'(wh);
    end
  endtask
  task automatic run(input int xv, input int wf, input int wh, input bit clr, output int l);
    set_in(xv, wf, wh);
    bus.clear_h = clr;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.clear_h = 1'b0;
    l = 0;
    while (!bus.done && l < 20) begin
      tick();
      l++;
    end
  endtask
  task automatic chk_h(input string tag, input int exp);
    chk({tag, "_h0"}, int'($signed(bus.oHid[0])), exp);
    chk({tag, "_h1"}, int'($signed(bus.oHid[1])), exp);
  endtask
  initial begin
    bus.start = 1'b1;
    bus.clear_h = 1'b0;
    set_in(0, 0, 0);
    tick();
    tick();
    chk_h("reset", 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    chk("post_reset_busy", int'(bus.busy), 0);
    run(101, 127, 32, 1'b1, lat);
    chk("preload_lat", lat, 9);
    chk_h("preload", 100);
    run(5, 0, 0, 1'b0, lat);
    chk("zero_w_lat", lat, 9);
    chk_h("zero_w", 50);
    run(101, 127, 32, 1'b1, lat);
    chk_h("clear_h", 100);
    run(127, 127, 127, 1'b1, lat);
    chk("pos_sat_lat", lat, 9);
    chk_h("pos_sat", 126);
    run(127, 127, -128, 1'b1, lat);
    chk_h("neg_sat", -127);
    set_in(5, 0, 0);
    bus.start = 1'b1;
    tick();
    chk("busy_after_start", int'(bus.busy), 1);
    n = 0;
    d1 = 0;
    d2 = 0;
    for (int c = 2; c <= 25; c++) begin
      bus.start = (c == 4) || (d1 != 0 && c == d1 + 1);
      tick();
      if (bus.done) begin
        n++;
        if (n == 1) begin
          d1 = c;
          chk_h("busy_first", -64);
          chk("busy_at_done", int'(bus.busy), 0);
        end else if (n == 2) d2 = c;
      end
    end
    bus.start = 1'b0;
    chk("busy_done_count", n, 2);
    chk("busy_first_cycle", d1, 10);
    chk("busy_second_cycle", d2, 20);
    chk_h("busy_second", -32);
    set_in(127, 127, 127);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk_h("abort", 0);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.done) n++;
    end
    chk("abort_no_done", n, 0);
    run(127, 127, 127, 1'b0, lat);
    chk("after_abort_lat", lat, 9);
    chk_h("after_abort", 126);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
